// File: rtl/sd_bkram_xfer.sv
// ---------------------------------------------------------------------------
// sd_bkram_xfer
// Moves a backup-RAM image between an SD-card volume and a 16-bit RAM port,
// one 512-byte sector at a time. A rising edge on bk_load reads the volume
// into RAM; a rising edge on bk_save writes RAM back to the volume. Sectors
// 0..count-1 are transferred, where count = min(SECTORS, image size / 512).
//
// Optional feature: define SD_BKRAM_DIRTY_EN to track a dirty flag (set by
// core_wr). When enabled, a save request with a clean RAM is dropped.
//
// Ports
//   clk_sys, reset        clock, asynchronous active-high reset
//   img_mounted, img_size volume mount pulse and image size in bytes
//   bk_load, bk_save      level requests (acted on at their rising edge)
//   bk_ena                volume mounted with nonzero size
//   bk_loading, bk_saving transfer in progress, by direction
//   sd_lba, sd_rd, sd_wr  sector request towards the SD responder
//   sd_ack                responder busy with the requested sector
//   sd_buff_*             word-level data exchange within a sector
//   mem_addr/wr/wdata     RAM write side (registered during load)
//   mem_rdata             RAM read data, valid one cycle after mem_addr
//   core_wr               core wrote backup RAM (dirty tracking only)
// ---------------------------------------------------------------------------
module sd_bkram_xfer #(
  parameter int SECTORS = 256,
  parameter int AW      = 16
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          img_mounted,
  input  logic [63:0]   img_size,
  input  logic          bk_load,
  input  logic          bk_save,
  output logic          bk_ena,
  output logic          bk_loading,
  output logic          bk_saving,
  output logic [31:0]   sd_lba,
  output logic          sd_rd,
  output logic          sd_wr,
  input  logic          sd_ack,
  input  logic [7:0]    sd_buff_addr,
  input  logic [15:0]   sd_buff_dout,
  input  logic          sd_buff_wr,
  output logic [15:0]   sd_buff_din,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic [15:0]   mem_wdata,
  input  logic [15:0]   mem_rdata,
  input  logic          core_wr
);

  // count must hold the value SECTORS itself, hence one bit above log2
  localparam int CW = AW - 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_NEXT = 2'd3
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   count_r;
  logic            bk_ena_r;
  logic            loading_r;
  logic            saving_r;
  logic            sd_rd_r;
  logic            sd_wr_r;
  logic            mem_wr_r;
  logic [31:0]     sd_lba_r;
  logic [AW-1:0]   mem_addr_r;
  logic [15:0]     mem_wdata_r;
  logic            load_prev_r;
  logic            save_prev_r;
  logic            abort_r;

  logic [54:0]     img_sectors_s;
  logic [CW-1:0]   count_next_s;
  logic            load_rise_s;
  logic            save_rise_s;
  logic            save_ok_s;
  logic            can_start_s;
  logic            last_s;
  logic [AW-1:0]   sector_addr_s;

`ifdef SD_BKRAM_DIRTY_EN
  logic            dirty_r;
  assign save_ok_s = save_rise_s & dirty_r;
`else
  logic            core_wr_unused_s;
  assign core_wr_unused_s = core_wr;
  assign save_ok_s        = save_rise_s;
`endif

  assign img_sectors_s = img_size[63:9];
  assign count_next_s  = (img_sectors_s >= 55'(SECTORS)) ? CW'(SECTORS)
                                                         : img_sectors_s[CW-1:0];
  assign load_rise_s   = bk_load & ~load_prev_r;
  assign save_rise_s   = bk_save & ~save_prev_r;
  assign can_start_s   = bk_ena_r && (count_r != {CW{1'b0}});
  assign last_s        = (sd_lba_r == (32'(count_r) - 32'd1));
  assign sector_addr_s = {sd_lba_r[AW-9:0], sd_buff_addr};

  // Save reads RAM combinationally so the responder sees data one cycle later
  assign mem_addr    = saving_r ? sector_addr_s : mem_addr_r;
  assign sd_buff_din = mem_rdata;
  assign mem_wdata   = mem_wdata_r;
  assign mem_wr      = mem_wr_r;
  assign sd_rd       = sd_rd_r;
  assign sd_wr       = sd_wr_r;
  assign sd_lba      = sd_lba_r;
  assign bk_ena      = bk_ena_r;
  assign bk_loading  = loading_r;
  assign bk_saving   = saving_r;

  // Mount latching and request edge detectors. Detectors reset to "high
  // seen" so a request held through reset does not start a transfer.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      count_r     <= {CW{1'b0}};
      bk_ena_r    <= 1'b0;
      load_prev_r <= 1'b1;
      save_prev_r <= 1'b1;
    end else begin
      load_prev_r <= bk_load;
      save_prev_r <= bk_save;
      if (img_mounted) begin
        count_r  <= count_next_s;
        bk_ena_r <= (img_size != 64'd0);
      end
    end
  end

  // Transfer FSM with registered request, status and RAM-write outputs
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      loading_r   <= 1'b0;
      saving_r    <= 1'b0;
      sd_rd_r     <= 1'b0;
      sd_wr_r     <= 1'b0;
      mem_wr_r    <= 1'b0;
      sd_lba_r    <= 32'd0;
      mem_addr_r  <= {AW{1'b0}};
      mem_wdata_r <= 16'd0;
      abort_r     <= 1'b0;
`ifdef SD_BKRAM_DIRTY_EN
      dirty_r     <= 1'b0;
`endif
    end else begin
      mem_wr_r <= 1'b0;
      // A remount mid-transfer lets the current sector finish, then stops
      if (img_mounted && (state_r != ST_IDLE)) begin
        abort_r <= 1'b1;
      end
`ifdef SD_BKRAM_DIRTY_EN
      if (core_wr) begin
        dirty_r <= 1'b1;
      end
`endif
      case (state_r)
        ST_IDLE: begin
          abort_r <= 1'b0;
          if (can_start_s && load_rise_s) begin
            loading_r <= 1'b1;
            saving_r  <= 1'b0;
            sd_rd_r   <= 1'b1;
            sd_lba_r  <= 32'd0;
            state_r   <= ST_REQ;
          end else if (can_start_s && save_ok_s) begin
            loading_r <= 1'b0;
            saving_r  <= 1'b1;
            sd_wr_r   <= 1'b1;
            sd_lba_r  <= 32'd0;
            state_r   <= ST_REQ;
          end else begin
            loading_r <= 1'b0;
            saving_r  <= 1'b0;
          end
        end
        ST_REQ: begin
          if (sd_ack) begin
            sd_rd_r <= 1'b0;
            sd_wr_r <= 1'b0;
            state_r <= ST_XFER;
          end
        end
        ST_XFER: begin
          // Strobes are only taken while sd_ack is high, so the write pulse
          // always lands before the FSM leaves XFER
          if (!sd_ack) begin
            state_r <= ST_NEXT;
          end else if (loading_r && sd_buff_wr) begin
            mem_wr_r    <= 1'b1;
            mem_addr_r  <= sector_addr_s;
            mem_wdata_r <= sd_buff_dout;
          end
        end
        ST_NEXT: begin
          if (abort_r || img_mounted) begin
            loading_r <= 1'b0;
            saving_r  <= 1'b0;
            state_r   <= ST_IDLE;
          end else if (last_s) begin
            loading_r <= 1'b0;
            saving_r  <= 1'b0;
            state_r   <= ST_IDLE;
`ifdef SD_BKRAM_DIRTY_EN
            if (!core_wr) begin
              dirty_r <= 1'b0;
            end
`endif
          end else begin
            sd_lba_r <= sd_lba_r + 32'd1;
            sd_rd_r  <= loading_r;
            sd_wr_r  <= saving_r;
            state_r  <= ST_REQ;
          end
        end
        default: begin
          loading_r <= 1'b0;
          saving_r  <= 1'b0;
          sd_rd_r   <= 1'b0;
          sd_wr_r   <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
